// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: load/capture/unload/compare sequencer for one scan chain
// Ports:
//   CLK, RSTB          clock (shared with the chain), async active-low reset
//   start, abort       run request (accepted in IDLE only), synchronous abort (wins over start)
//   pat_in, exp_in,    stimulus, expected capture and compare mask,
//   exp_mask           all latched when start is accepted
//   chain_so           scan out of the last cell
//   chain_se, chain_si scan enable to every cell, scan in to cell 0
//   busy, done         run in progress, one-cycle completion pulse
//   pass, captured     compare result and unloaded chain of the last completed run
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic [CHAIN_LEN-1:0] exp_mask,
    input  logic                 chain_so,
    output logic                 chain_se,
    output logic                 chain_si,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d, exp_q, exp_d, mask_q, mask_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d, cap_q, cap_d;
    logic                 pass_q, pass_d, se_q, si_q, busy_q, done_q;
    logic                 last;
    assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
    // Unload goes into a private shift register and is committed to captured only
    // on DONE entry, so an aborted run leaves the previous result untouched.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        sh_d    = sh_q;
        cap_d   = cap_q;
        pass_d  = pass_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = SHIFT_IN;
                    pat_d   = pat_in;
                    exp_d   = exp_in;
                    mask_d  = exp_mask;
                end
                SHIFT_IN: begin
                    pat_d   = pat_q << 1;
                    state_d = last ? CAPTURE : SHIFT_IN;
                end
                CAPTURE: state_d = SHIFT_OUT;
                SHIFT_OUT: begin
                    sh_d = {sh_q[CHAIN_LEN-2:0], chain_so};
                    if (last) begin
                        state_d = DONE;
                        cap_d   = sh_d;
                        pass_d  = &(~((sh_d ^ exp_q) & mask_q));
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            sh_q    <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            se_q    <= state_d == SHIFT_IN || state_d == SHIFT_OUT;
            si_q    <= state_d == SHIFT_IN && pat_d[CHAIN_LEN-1];
            busy_q  <= state_d == SHIFT_IN || state_d == CAPTURE || state_d == SHIFT_OUT;
            done_q  <= state_d == DONE;
        end
    end
    assign chain_se = se_q;
    assign chain_si = si_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = cap_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl driving a 16-cell inverting scan chain model
module tb_scan_chain_ctrl;
    logic        CLK = 1'b0, RSTB = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] pat_in = '0, exp_in = '0, exp_mask = '0;
    logic        chain_so, chain_se, chain_si, busy, done, pass;
    logic [15:0] captured, cells;
    int          nchk = 0, nfail = 0, cyc = 0;

    scan_chain_ctrl #(.CHAIN_LEN(16)) dut (
        .CLK(CLK), .RSTB(RSTB), .start(start), .abort(abort),
        .pat_in(pat_in), .exp_in(exp_in), .exp_mask(exp_mask), .chain_so(chain_so),
        .chain_se(chain_se), .chain_si(chain_si), .busy(busy), .done(done),
        .pass(pass), .captured(captured)
    );

    always #5 CLK = ~CLK;

    // Scan cells: shift from chain_si toward cell 15 when enabled, functional D = ~Q otherwise.
    always_ff @(posedge CLK or negedge RSTB)
        if (!RSTB) cells <= '0;
        else cells <= chain_se ? {cells[14:0], chain_si} : ~cells;
    assign chain_so = cells[15];

    task automatic chk1(input string tag, input logic obs, input logic expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic zero_outs(input string tag);
        chk1({tag, "_se"}, chain_se, 1'b0);
        chk1({tag, "_si"}, chain_si, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_pass"}, pass, 1'b0);
        chk16({tag, "_cap"}, captured, 16'h0000);
    endtask

    // Leaves the bench 1 time unit into cycle 1 (start accepted at edge 0).
    task automatic begin_run(input logic [15:0] p, input logic [15:0] e, input logic [15:0] m);
        pat_in   = p;
        exp_in   = e;
        exp_mask = m;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        cyc   = 1;
        start = 1'b0;
    endtask

    task automatic full_run(input logic [15:0] p, input logic [15:0] e, input logic [15:0] m,
                            input logic [15:0] cap, input logic ps, input bit disturb);
        logic si_exp;
        begin_run(p, e, m);
        while (cyc < 34) begin
            si_exp = 1'b0;
            if (cyc <= 16) si_exp = p[16-cyc];
            chk1("se", chain_se, cyc != 17);
            chk1("si", chain_si, si_exp);
            chk1("busy", busy, 1'b1);
            chk1("done_early", done, 1'b0);
            if (disturb && cyc == 5) begin
                start  = 1'b1;
                pat_in = ~p;
            end
            if (disturb && cyc == 6) start = 1'b0;
            tick();
        end
        chk1("done", done, 1'b1);
        chk1("busy_done", busy, 1'b0);
        chk1("se_done", chain_se, 1'b0);
        chk16("captured", captured, cap);
        chk1("pass", pass, ps);
        if (disturb) start = 1'b1;
        tick();
        start = 1'b0;
        chk1("done_after", done, 1'b0);
        chk1("busy_after", busy, 1'b0);
        tick();
        chk1("busy_after2", busy, 1'b0);
    endtask

    initial begin
        // 1. reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            abort    = 1'($urandom);
            pat_in   = 16'($urandom);
            exp_in   = 16'($urandom);
            exp_mask = 16'($urandom);
            tick();
            zero_outs("rst");
        end
        start = 1'b0;
        abort = 1'b0;
        RSTB  = 1'b1;
        tick();
        tick();
        chk1("idle_se", chain_se, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        // 2. basic run, 4. ignored starts and pattern changes, 3. mask cases
        full_run(16'hA5C3, 16'h5A3C, 16'hFFFF, 16'h5A3C, 1'b1, 1'b0);
        full_run(16'hA5C3, 16'h5A3C, 16'hFFFF, 16'h5A3C, 1'b1, 1'b1);
        full_run(16'hA5C3, 16'h5A3D, 16'hFFFE, 16'h5A3C, 1'b1, 1'b0);
        full_run(16'hA5C3, 16'h5A3D, 16'hFFFF, 16'h5A3C, 1'b0, 1'b0);
        // 5. abort in cycle 20 keeps the previous (failing) result
        begin_run(16'h1234, 16'h0000, 16'hFFFF);
        while (cyc < 20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_se", chain_se, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_pass", pass, 1'b0);
        chk16("abort_cap", captured, 16'h5A3C);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk1("abort_nodone", done, 1'b0);
        end
        full_run(16'h0F0F, 16'hF0F0, 16'hFFFF, 16'hF0F0, 1'b1, 1'b0);
        // 6. async reset in the middle of cycle 25
        begin_run(16'hA5C3, 16'h5A3C, 16'hFFFF);
        while (cyc < 25) tick();
        #3;
        RSTB = 1'b0;
        #1;
        zero_outs("midrst");
        tick();
        chk1("midrst_nodone", done, 1'b0);
        RSTB = 1'b1;
        tick();
        full_run(16'hA5C3, 16'h5A3C, 16'hFFFF, 16'h5A3C, 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
